// File: rtl/serial_demo_pkg.sv
// Shared state encoding, default timing constants and helpers for the serial echo demo blocks.
package serial_demo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_READY,
    SEND_WAIT,
    SEND_CLR,
    AWAIT_RX,
    RX_READ,
    GAP,
    DONE
  } echo_state_t;

  localparam int unsigned DEF_BYTE_COUNT       = 16;
  localparam logic [7:0]  DEF_PATTERN_START    = 8'h00;
  localparam logic [31:0] DEF_RESPONSE_TIMEOUT = 32'd5000000;
  localparam logic [3:0]  DEF_RX_READ_HOLD     = 4'd10;
  localparam logic [3:0]  DEF_INTER_BYTE_GAP   = 4'd10;

  // Error counters stick at all-ones rather than wrapping back to a clean-looking value.
  function automatic logic [15:0] err_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/serial_echo_checker.sv
// Sends a byte pattern through a transmitter handshake and checks that every echoed
// byte equals the sent byte plus one, counting mismatches, receiver errors and timeouts.
module serial_echo_checker
  import serial_demo_pkg::*;
#(
  parameter int unsigned BYTE_COUNT       = DEF_BYTE_COUNT,
  parameter logic [7:0]  PATTERN_START    = DEF_PATTERN_START,
  parameter logic [31:0] RESPONSE_TIMEOUT = DEF_RESPONSE_TIMEOUT,
  parameter logic [3:0]  RX_READ_HOLD     = DEF_RX_READ_HOLD,
  parameter logic [3:0]  INTER_BYTE_GAP   = DEF_INTER_BYTE_GAP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        tx_transaction,
  output logic [7:0]  tx_data,
  output logic        tx_data_ready,
  input  logic        tx_data_copied,
  input  logic        rx_byte_received,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  output logic        rx_read,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [7:0]  last_expected,
  output logic [7:0]  last_received
);

  localparam logic [15:0] LAST_INDEX  = 16'(BYTE_COUNT - 1);
  localparam logic [31:0] HOLD_CYCLES = {28'd0, RX_READ_HOLD};
  localparam logic [31:0] GAP_CYCLES  = {28'd0, INTER_BYTE_GAP};

  echo_state_t state_q, state_d;
  logic [15:0] index_q, index_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] err_q, err_d;
  logic [7:0]  exp_q, exp_d;
  logic [7:0]  rcv_q, rcv_d;
  logic [7:0]  echo_expected;
  logic [15:0] next_index;
  logic [31:0] cnt_next;

  assign echo_expected = tx_data_q + 8'd1;
  assign next_index    = index_q + 16'd1;
  assign cnt_next      = cnt_q + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      index_q   <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      err_q     <= '0;
      exp_q     <= '0;
      rcv_q     <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      exp_q     <= exp_d;
      rcv_q     <= rcv_d;
    end
  end

  // One shared cycle counter serves the timeout, the read hold and the gap; it is
  // cleared on every transition into a timed state.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    err_d     = err_q;
    exp_d     = exp_q;
    rcv_d     = rcv_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SEND_READY;
          index_d   = '0;
          cnt_d     = '0;
          err_d     = '0;
          tx_data_d = PATTERN_START;
        end
      end
      SEND_READY: begin
        if (tx_data_copied) state_d = SEND_WAIT;
      end
      SEND_WAIT: begin
        if (!tx_data_copied) state_d = SEND_CLR;
      end
      SEND_CLR: begin
        state_d = AWAIT_RX;
        cnt_d   = '0;
      end
      AWAIT_RX: begin
        if (rx_byte_received) begin
          rcv_d   = rx_data;
          exp_d   = echo_expected;
          if ((rx_data != echo_expected) || rx_err) err_d = err_inc(err_q);
          state_d = RX_READ;
          cnt_d   = '0;
        end else if (cnt_next >= RESPONSE_TIMEOUT) begin
          exp_d   = echo_expected;
          err_d   = err_inc(err_q);
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_next;
        end
      end
      RX_READ: begin
        if (cnt_next >= HOLD_CYCLES) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_next;
        end
      end
      GAP: begin
        if (cnt_next >= GAP_CYCLES) begin
          cnt_d = '0;
          if (index_q == LAST_INDEX) begin
            state_d = DONE;
          end else begin
            index_d   = next_index;
            tx_data_d = PATTERN_START + next_index[7:0];
            state_d   = SEND_READY;
          end
        end else begin
          cnt_d = cnt_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_transaction = (state_q == SEND_READY) || (state_q == SEND_WAIT);
  assign tx_data_ready  = (state_q == SEND_READY) || (state_q == SEND_WAIT);
  assign tx_data        = tx_data_q;
  assign rx_read        = (state_q == RX_READ);
  assign busy           = (state_q != IDLE) && (state_q != DONE);
  assign done           = (state_q == DONE);
  assign pass           = (state_q == DONE) && (err_q == 16'd0);
  assign err_count      = err_q;
  assign last_expected  = exp_q;
  assign last_received  = rcv_q;

endmodule

// File: tb/tb_serial_echo_checker.sv
// Self-checking bench: two checker instances, each looped back through a randomly timed
// echo model that can drop, corrupt or flag individual bytes.
module tb_serial_echo_checker;

  localparam logic [7:0]  P0 = 8'h10;
  localparam int          N0 = 4;
  localparam logic [7:0]  P1 = 8'hFE;
  localparam int          N1 = 3;
  localparam logic [31:0] TO = 32'd100;
  localparam int          HOLD0 = 3;
  localparam int          GAP0  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        start_i  [2];
  logic        copied_i [2];
  logic        rxv_i    [2];
  logic [7:0]  rxd_i    [2];
  logic        rxe_i    [2];
  logic        txn_o    [2];
  logic        txrdy_o  [2];
  logic [7:0]  txd_o    [2];
  logic        rdo_o    [2];
  logic        busy_o   [2];
  logic        done_o   [2];
  logic        pass_o   [2];
  logic [15:0] err_o    [2];
  logic [7:0]  lexp_o   [2];
  logic [7:0]  lrcv_o   [2];

  int         drop_k [2];
  int         same_k [2];
  int         rxerr_k[2];
  int         hs_cnt [2];
  int         gap_meas[2];
  int         rd_len [2];
  logic [7:0] sent_log[2][16];
  logic [7:0] snap_exp[2][16];
  logic [7:0] snap_rcv[2][16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_echo_checker #(
    .BYTE_COUNT(N0), .PATTERN_START(P0), .RESPONSE_TIMEOUT(TO),
    .RX_READ_HOLD(4'(HOLD0)), .INTER_BYTE_GAP(4'(GAP0))
  ) dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]),
    .tx_transaction(txn_o[0]), .tx_data(txd_o[0]), .tx_data_ready(txrdy_o[0]),
    .tx_data_copied(copied_i[0]), .rx_byte_received(rxv_i[0]), .rx_data(rxd_i[0]),
    .rx_err(rxe_i[0]), .rx_read(rdo_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .err_count(err_o[0]), .last_expected(lexp_o[0]),
    .last_received(lrcv_o[0])
  );

  serial_echo_checker #(
    .BYTE_COUNT(N1), .PATTERN_START(P1), .RESPONSE_TIMEOUT(TO),
    .RX_READ_HOLD(4'd2), .INTER_BYTE_GAP(4'd3)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]),
    .tx_transaction(txn_o[1]), .tx_data(txd_o[1]), .tx_data_ready(txrdy_o[1]),
    .tx_data_copied(copied_i[1]), .rx_byte_received(rxv_i[1]), .rx_data(rxd_i[1]),
    .rx_err(rxe_i[1]), .rx_read(rdo_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .err_count(err_o[1]), .last_expected(lexp_o[1]),
    .last_received(lrcv_o[1])
  );

  // Error count for a run: every byte that is dropped, echoed wrongly or flagged costs one.
  function automatic int model_errs(input int n, input int d, input int s, input int e);
    int c = 0;
    for (int k = 0; k < n; k++) if (k == d || k == s || k == e) c++;
    return c;
  endfunction

  // Echo model: completes the copy handshake, then answers with byte+1 after a random delay.
  task automatic xcvr(input int sel);
    logic [7:0] b, off, pst;
    int n, k;
    pst = (sel == 0) ? P0 : P1;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txrdy_o[sel] === 1'b1 && copied_i[sel] === 1'b0) begin
        b = txd_o[sel];
        off = b - pst;
        n = int'(off);
        if (n < 16) sent_log[sel][n] = b;
        hs_cnt[sel]++;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        copied_i[sel] = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        copied_i[sel] = 1'b0;
        k = 0;
        while (txrdy_o[sel] === 1'b1 && k < 50) begin @(negedge clk); k++; end
        if (n == drop_k[sel]) begin
          k = 0;
          while (txrdy_o[sel] !== 1'b1 && done_o[sel] !== 1'b1 && k < 1000) begin
            @(negedge clk); k++;
          end
          gap_meas[sel] = k;
        end else begin
          repeat ($urandom_range(1, 5)) @(negedge clk);
          rxd_i[sel] = (n == same_k[sel]) ? b : b + 8'd1;
          rxe_i[sel] = (n == rxerr_k[sel]);
          rxv_i[sel] = 1'b1;
          k = 0;
          while (rdo_o[sel] !== 1'b1 && k < 500) begin @(negedge clk); k++; end
          if (n < 16) begin
            snap_exp[sel][n] = lexp_o[sel];
            snap_rcv[sel][n] = lrcv_o[sel];
          end
          rxv_i[sel] = 1'b0;
          rxe_i[sel] = 1'b0;
        end
      end
    end
  endtask

  task automatic mon(input int sel);
    int cur = 0;
    forever begin
      @(negedge clk);
      if (rdo_o[sel] === 1'b1) cur++;
      else begin
        if (cur != 0) rd_len[sel] = cur;
        cur = 0;
      end
    end
  endtask

  task automatic run_dut(input int sel, input int drop, input int same, input int rxe);
    int k;
    drop_k[sel] = drop; same_k[sel] = same; rxerr_k[sel] = rxe;
    hs_cnt[sel] = 0;
    for (int j = 0; j < 16; j++) begin
      sent_log[sel][j] = 'x; snap_exp[sel][j] = 'x; snap_rcv[sel][j] = 'x;
    end
    @(negedge clk); start_i[sel] = 1'b1;
    @(negedge clk); start_i[sel] = 1'b0;
    k = 0;
    while (done_o[sel] !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
    total++;
    if (done_o[sel] !== 1'b1) begin
      bad++; $display("[TB] FAIL run_complete dut%0d: done=%b required 1", sel, done_o[sel]);
    end
  endtask

  task automatic test_reset();
    #12;
    for (int s = 0; s < 2; s++) begin
      total++;
      if ({txn_o[s], txrdy_o[s], txd_o[s], rdo_o[s], busy_o[s], done_o[s], pass_o[s],
           err_o[s], lexp_o[s], lrcv_o[s]} !== 46'd0) begin
        bad++; $display("[TB] FAIL reset_outputs dut%0d: got %h required 0", s,
          {txn_o[s], txrdy_o[s], txd_o[s], rdo_o[s], busy_o[s], done_o[s], pass_o[s],
           err_o[s], lexp_o[s], lrcv_o[s]});
      end
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_loopback();
    run_dut(0, -1, -1, -1);
    for (int k = 0; k < N0; k++) begin
      total++;
      if (sent_log[0][k] !== 8'(P0 + k) || snap_exp[0][k] !== 8'(P0 + k + 1) ||
          snap_rcv[0][k] !== 8'(P0 + k + 1)) begin
        bad++; $display("[TB] FAIL loopback_byte%0d: sent=%h exp=%h rcv=%h required %h/%h/%h",
          k, sent_log[0][k], snap_exp[0][k], snap_rcv[0][k], 8'(P0 + k), 8'(P0 + k + 1), 8'(P0 + k + 1));
      end
    end
    total++;
    if (err_o[0] !== 16'd0 || pass_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
      bad++; $display("[TB] FAIL loopback_result: err=%0d pass=%b busy=%b required 0/1/0",
        err_o[0], pass_o[0], busy_o[0]);
    end
    total++;
    if (rd_len[0] != HOLD0) begin
      bad++; $display("[TB] FAIL rx_read_hold: got %0d required %0d", rd_len[0], HOLD0);
    end
  endtask

  task automatic test_ignore_rx();
    logic rd_seen = 1'b0;
    @(negedge clk);
    rxd_i[0] = 8'h77; rxe_i[0] = 1'b1; rxv_i[0] = 1'b1;
    repeat (10) begin @(negedge clk); if (rdo_o[0] !== 1'b0) rd_seen = 1'b1; end
    rxv_i[0] = 1'b0; rxe_i[0] = 1'b0;
    total++;
    if (err_o[0] !== 16'd0 || rd_seen !== 1'b0 || done_o[0] !== 1'b1) begin
      bad++; $display("[TB] FAIL ignore_rx: err=%0d rd_seen=%b done=%b required 0/0/1",
        err_o[0], rd_seen, done_o[0]);
    end
  endtask

  task automatic test_wrap();
    run_dut(1, -1, -1, -1);
    for (int k = 0; k < N1; k++) begin
      total++;
      if (sent_log[1][k] !== 8'(P1 + k) || snap_exp[1][k] !== 8'(P1 + k + 1)) begin
        bad++; $display("[TB] FAIL wrap_byte%0d: sent=%h exp=%h required %h/%h",
          k, sent_log[1][k], snap_exp[1][k], 8'(P1 + k), 8'(P1 + k + 1));
      end
    end
    total++;
    if (err_o[1] !== 16'd0 || pass_o[1] !== 1'b1) begin
      bad++; $display("[TB] FAIL wrap_result: err=%0d pass=%b required 0/1", err_o[1], pass_o[1]);
    end
  endtask

  task automatic test_mismatch();
    run_dut(0, -1, 2, -1);
    total++;
    if (err_o[0] !== 16'd1 || pass_o[0] !== 1'b0) begin
      bad++; $display("[TB] FAIL mismatch_result: err=%0d pass=%b required 1/0", err_o[0], pass_o[0]);
    end
    total++;
    if (snap_exp[0][2] !== 8'(P0 + 3) || snap_rcv[0][2] !== 8'(P0 + 2)) begin
      bad++; $display("[TB] FAIL mismatch_values: exp=%h rcv=%h required %h/%h",
        snap_exp[0][2], snap_rcv[0][2], 8'(P0 + 3), 8'(P0 + 2));
    end
  endtask

  task automatic test_timeout();
    run_dut(0, 1, -1, -1);
    total++;
    if (gap_meas[0] != 1 + int'(TO) + GAP0) begin
      bad++; $display("[TB] FAIL timeout_length: got %0d cycles required %0d",
        gap_meas[0], 1 + int'(TO) + GAP0);
    end
    total++;
    if (err_o[0] !== 16'd1 || pass_o[0] !== 1'b0 || sent_log[0][3] !== 8'(P0 + 3)) begin
      bad++; $display("[TB] FAIL timeout_result: err=%0d pass=%b last_sent=%h required 1/0/%h",
        err_o[0], pass_o[0], sent_log[0][3], 8'(P0 + 3));
    end
  endtask

  task automatic test_rx_err_and_start();
    fork
      run_dut(0, -1, -1, 0);
      begin
        repeat (30) @(negedge clk);
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
      end
    join
    total++;
    if (err_o[0] !== 16'd1 || pass_o[0] !== 1'b0) begin
      bad++; $display("[TB] FAIL rx_err_result: err=%0d pass=%b required 1/0", err_o[0], pass_o[0]);
    end
    total++;
    if (hs_cnt[0] != N0) begin
      bad++; $display("[TB] FAIL start_while_busy: handshakes=%0d required %0d", hs_cnt[0], N0);
    end
  endtask

  task automatic test_random();
    int d, s, e, want;
    for (int it = 0; it < 6; it++) begin
      d = int'($urandom_range(0, 5)) - 1;
      s = int'($urandom_range(0, 5)) - 1;
      e = int'($urandom_range(0, 5)) - 1;
      want = model_errs(N0, d, s, e);
      run_dut(0, d, s, e);
      total++;
      if (err_o[0] !== 16'(want) || pass_o[0] !== (want == 0)) begin
        bad++; $display("[TB] FAIL random_run%0d (d=%0d s=%0d e=%0d): err=%0d pass=%b required %0d/%b",
          it, d, s, e, err_o[0], pass_o[0], want, (want == 0));
      end
    end
  endtask

  task automatic test_reset_midrun();
    int k;
    @(negedge clk); start_i[0] = 1'b1;
    @(negedge clk); start_i[0] = 1'b0;
    k = 0;
    while (rdo_o[0] !== 1'b1 && k < 500) begin @(negedge clk); k++; end
    total++;
    if (rdo_o[0] !== 1'b1 || busy_o[0] !== 1'b1) begin
      bad++; $display("[TB] FAIL midrun_reach_read: rx_read=%b busy=%b required 1/1", rdo_o[0], busy_o[0]);
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({txn_o[0], txrdy_o[0], txd_o[0], rdo_o[0], busy_o[0], done_o[0], pass_o[0],
         err_o[0], lexp_o[0], lrcv_o[0]} !== 46'd0) begin
      bad++; $display("[TB] FAIL midrun_reset_outputs: got %h required 0",
        {txn_o[0], txrdy_o[0], txd_o[0], rdo_o[0], busy_o[0], done_o[0], pass_o[0],
         err_o[0], lexp_o[0], lrcv_o[0]});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run_dut(0, -1, -1, -1);
    total++;
    if (err_o[0] !== 16'd0 || pass_o[0] !== 1'b1 || hs_cnt[0] != N0 ||
        sent_log[0][0] !== P0 || lrcv_o[0] !== 8'(P0 + N0)) begin
      bad++; $display("[TB] FAIL after_reset_run: err=%0d pass=%b hs=%0d first=%h last_rcv=%h required 0/1/%0d/%h/%h",
        err_o[0], pass_o[0], hs_cnt[0], sent_log[0][0], lrcv_o[0], N0, P0, 8'(P0 + N0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      start_i[s] = 1'b0; copied_i[s] = 1'b0; rxv_i[s] = 1'b0; rxd_i[s] = 8'h00; rxe_i[s] = 1'b0;
      drop_k[s] = -1; same_k[s] = -1; rxerr_k[s] = -1;
      hs_cnt[s] = 0; gap_meas[s] = 0; rd_len[s] = 0;
    end
    fork
      xcvr(0);
      xcvr(1);
      mon(0);
      mon(1);
    join_none
    test_reset();
    test_loopback();
    test_ignore_rx();
    test_wrap();
    test_mismatch();
    test_timeout();
    test_rx_err_and_start();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
